nios_system_pio_irq: RTL and testbench
======================================

# nios_system_pio_irq

Parametrised Avalon-MM parallel I/O slave for the Nios II system: a width-configurable output register with atomic set/clear access, plus a synchronised input port with edge capture, per-bit interrupt mask and a level interrupt to the CPU. It sits on the system interconnect beside the existing output-only PIO slaves and replaces them wherever input sensing or interrupts are needed. Zero-wait-state writes and combinational reads, so it drops into the same interconnect slot.

## Interface
- DATA_WIDTH, 8: port width, legal range 1..32.
- RESET_VALUE, 0: out_port value after reset; DATA_WIDTH bits.
- EDGE_TYPE, 0: capture mode: 0 rising, 1 falling, 2 any edge.
- SYNC_STAGES, 2: input synchroniser depth, legal range 2..4.

- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  word register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data; bits above DATA_WIDTH ignored.
- readdata  out  32  read data; combinational from address; bits above DATA_WIDTH are 0.
- in_port  in  DATA_WIDTH  asynchronous external inputs.
- out_port  out  DATA_WIDTH  registered outputs (data_out).
- irq  out  1  level interrupt: OR of (edge_capture & irq_mask).

## Operation
- Register map (address: read / write):
  - 0 DATA: in_sync / data_out <= wd.
  - 1 IRQ_MASK: irq_mask / irq_mask <= wd.
  - 2 EDGE_CAPTURE: edge_capture / clear every bit written as 1.
  - 3 OUTSET: data_out / data_out <= data_out | wd.
  - 4 OUTCLEAR: data_out / data_out <= data_out & ~wd.
  - 5 DATA_OUT: data_out / no effect.
  - 6, 7: 0 / no effect.
- Writes take effect on the clk edge at which the write is asserted. Writes with chipselect=0 are ignored. Reads have no side effects.
- Synchroniser: SYNC_STAGES flops in series on in_port; the last stage is in_sync. in_prev is in_sync delayed one cycle.
- Edge detect per bit: rising = in_sync & ~in_prev; falling = ~in_sync & in_prev; any = in_sync ^ in_prev; selected by EDGE_TYPE.
- Warm-up: after reset deasserts, a counter suppresses edge detection for SYNC_STAGES+1 cycles. Once the count completes, it saturates and the armed flag stays 1 until the next reset. This prevents capturing the reset-to-live transition of the pipeline.
- Capture: edge_capture <= (edge_capture & ~clear_mask) | (armed ? edge : 0). On the same cycle as a clear, a new edge wins, so the bit stays 1.
- irq = |(edge_capture & irq_mask). It is a function of registers only, so it has no combinational path from the bus.
- Reset values: data_out = out_port = RESET_VALUE; irq_mask = 0; edge_capture = 0; synchroniser, in_prev and warm-up counter = 0; armed = 0; irq = 0. readdata follows the reset register contents.
- Reset asserted mid-operation clears all state immediately (asynchronous) and restarts warm-up.

## Timing
- Write latency: out_port, irq_mask and the cleared edge_capture bits all change at the clk edge that samples the write.
- Read: readdata is valid in the same cycle as address, with zero wait states.
- Input latency: an in_port change set up before edge E reaches in_sync at edge E+SYNC_STAGES-1. edge_capture and irq assert at edge E+SYNC_STAGES. With the default of 2, that is 2 edges after first sampling.
- Pulses shorter than one clk period are not guaranteed to be captured.
- A mask write takes effect on irq at the same edge as the write.

## Test plan
- Reset with RESET_VALUE=8'hA5: out_port=A5, irq=0, and a read at address 5 returns 32'h000000A5. Write 8'h3C to address 0 -> out_port=3C on the next edge.
- From out=3C: write 8'h81 to OUTSET -> BD; then write 8'h0C to OUTCLEAR -> B1. Bits 31:8 of writedata do not affect either result.
- EDGE_TYPE=0, mask=8'h01: drive in_port bit0 0->1 -> edge_capture=01 and irq=1 two edges later. Drive 1->0 -> no new capture. Write 01 to address 2 -> irq=0 on the next edge.
- Simultaneous event: a clear write to bit0 lands on the same edge as a new bit0 edge -> bit0 remains 1 and irq stays high.
- Hold in_port=FF through reset and release reset -> edge_capture stays 00 (warm-up suppression). Assert reset_n=0 mid-run with captures pending -> all registers return to reset values immediately.
- EDGE_TYPE=2, DATA_WIDTH=32, mask=0: toggle bit31 -> edge_capture[31]=1 with irq=0. Write mask=32'h80000000 -> irq=1 on the same edge.

Source files
------------

// File: rtl/nios_system_pio_irq_if.sv
//==============================================================================
// Module      : nios_system_pio_irq_if
// Description : Avalon-MM slave bus bundle for the PIO/IRQ peripheral.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface nios_system_pio_irq_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

`default_nettype wire

// File: rtl/nios_system_pio_irq.sv
//==============================================================================
// Module      : nios_system_pio_irq
// Description : Avalon-MM PIO with set/clear output, synchronised edge-capture
//               input, per-bit interrupt mask and level IRQ.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module nios_system_pio_irq #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned           EDGE_TYPE   = 0,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  wire logic                  clk,
  input  wire logic                  reset_n,
  nios_system_pio_irq_if.slave       bus,
  input  wire logic [DATA_WIDTH-1:0] in_port,
  output logic      [DATA_WIDTH-1:0] out_port,
  output logic                       irq
);

  localparam logic [2:0] c_ADDR_DATA     = 3'd0;
  localparam logic [2:0] c_ADDR_IRQ_MASK = 3'd1;
  localparam logic [2:0] c_ADDR_EDGE_CAP = 3'd2;
  localparam logic [2:0] c_ADDR_OUTSET   = 3'd3;
  localparam logic [2:0] c_ADDR_OUTCLR   = 3'd4;
  localparam logic [2:0] c_ADDR_DATA_OUT = 3'd5;
  localparam logic [2:0] c_WARM_LAST     = 3'(SYNC_STAGES);

  logic                                   wr_en_w;
  logic [DATA_WIDTH-1:0]                  wd_w;
  logic                                   unused_wd_w;

  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0]                  in_sync_w;
  logic [DATA_WIDTH-1:0]                  in_prev_q;
  logic [DATA_WIDTH-1:0]                  edge_w;

  logic [2:0]                             warm_q;
  logic                                   armed_q;

  logic [DATA_WIDTH-1:0]                  data_out_q, data_out_d;
  logic [DATA_WIDTH-1:0]                  irq_mask_q, irq_mask_d;
  logic [DATA_WIDTH-1:0]                  edge_cap_q, edge_cap_d;
  logic [DATA_WIDTH-1:0]                  clear_mask_w;
  logic [31:0]                            readdata_w;

  assign wr_en_w     = bus.chipselect & ~bus.write_n;
  assign wd_w        = bus.writedata[DATA_WIDTH-1:0];
  assign unused_wd_w = ^bus.writedata;

  // Input synchroniser: stage 0 samples the pin, the last stage is in_sync.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      in_prev_q <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], in_port};
      in_prev_q <= in_sync_w;
    end
  end

  assign in_sync_w = sync_q[SYNC_STAGES-1];

  generate
    if (EDGE_TYPE == 0) begin : g_edge_rise
      assign edge_w = in_sync_w & ~in_prev_q;
    end else if (EDGE_TYPE == 1) begin : g_edge_fall
      assign edge_w = ~in_sync_w & in_prev_q;
    end else begin : g_edge_any
      assign edge_w = in_sync_w ^ in_prev_q;
    end
  endgenerate

  // Detection stays disarmed until the synchroniser has flushed its reset zeros.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_q  <= '0;
      armed_q <= 1'b0;
    end else if (!armed_q) begin
      if (warm_q == c_WARM_LAST) begin
        armed_q <= 1'b1;
      end else begin
        warm_q <= warm_q + 3'd1;
      end
    end
  end

  always_comb begin
    data_out_d   = data_out_q;
    irq_mask_d   = irq_mask_q;
    clear_mask_w = '0;
    if (wr_en_w) begin
      case (bus.address)
        c_ADDR_DATA:     data_out_d   = wd_w;
        c_ADDR_IRQ_MASK: irq_mask_d   = wd_w;
        c_ADDR_EDGE_CAP: clear_mask_w = wd_w;
        c_ADDR_OUTSET:   data_out_d   = data_out_q | wd_w;
        c_ADDR_OUTCLR:   data_out_d   = data_out_q & ~wd_w;
        default:         ;
      endcase
    end
    // A fresh edge overrides a simultaneous clear of the same bit.
    edge_cap_d = (edge_cap_q & ~clear_mask_w) | (armed_q ? edge_w : '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_VALUE;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
    end else begin
      data_out_q <= data_out_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
    end
  end

  always_comb begin
    readdata_w = '0;
    case (bus.address)
      c_ADDR_DATA:     readdata_w[DATA_WIDTH-1:0] = in_sync_w;
      c_ADDR_IRQ_MASK: readdata_w[DATA_WIDTH-1:0] = irq_mask_q;
      c_ADDR_EDGE_CAP: readdata_w[DATA_WIDTH-1:0] = edge_cap_q;
      c_ADDR_OUTSET,
      c_ADDR_OUTCLR,
      c_ADDR_DATA_OUT: readdata_w[DATA_WIDTH-1:0] = data_out_q;
      default:         readdata_w = '0;
    endcase
  end

  assign bus.readdata = readdata_w;
  assign out_port     = data_out_q;
  assign irq          = |(edge_cap_q & irq_mask_q);

endmodule

`default_nettype wire

// File: tb/tb_nios_system_pio_irq.sv
//==============================================================================
// Module      : tb_nios_system_pio_irq
// Description : Directed bench for three PIO configurations (rising/8-bit,
//               any-edge/32-bit, falling/4-bit with 3 sync stages).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_nios_system_pio_irq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [7:0]  in8,  out8;
  logic        irq8;
  logic [31:0] in32, out32;
  logic        irq32;
  logic [3:0]  inf,  outf;
  logic        irqf;
  logic [31:0] q;

  int errors = 0;
  int checks = 0;

  nios_system_pio_irq_if b8 ();
  nios_system_pio_irq_if b32 ();
  nios_system_pio_irq_if bf ();

  nios_system_pio_irq #(.DATA_WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .reset_n(reset_n), .bus(b8.slave), .in_port(in8), .out_port(out8), .irq(irq8));

  nios_system_pio_irq #(.DATA_WIDTH(32), .RESET_VALUE(32'h0), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut32 (
    .clk(clk), .reset_n(reset_n), .bus(b32.slave), .in_port(in32), .out_port(out32), .irq(irq32));

  nios_system_pio_irq #(.DATA_WIDTH(4), .RESET_VALUE(4'h9), .EDGE_TYPE(1), .SYNC_STAGES(3)) dutf (
    .clk(clk), .reset_n(reset_n), .bus(bf.slave), .in_port(inf), .out_port(outf), .irq(irqf));

  task automatic bus_drive(input int sel, input logic [2:0] a, input logic [31:0] d,
                           input logic cs, input logic wn);
    case (sel)
      0: begin b8.address = a;  b8.writedata = d;  b8.chipselect = cs;  b8.write_n = wn;  end
      1: begin b32.address = a; b32.writedata = d; b32.chipselect = cs; b32.write_n = wn; end
      default: begin bf.address = a; bf.writedata = d; bf.chipselect = cs; bf.write_n = wn; end
    endcase
  endtask

  task automatic bus_wr(input int sel, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_drive(sel, a, d, 1'b1, 1'b0);
    @(negedge clk);
    bus_drive(sel, a, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic bus_rd(input int sel, input logic [2:0] a, output logic [31:0] r);
    bus_drive(sel, a, 32'h0, 1'b0, 1'b1);
    #1;
    case (sel)
      0:       r = b8.readdata;
      1:       r = b32.readdata;
      default: r = bf.readdata;
    endcase
  endtask

  task automatic test_reset;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out8 !== 8'hA5) begin errors++; $display("FAIL reset_out8: got %h want a5", out8); end
    checks++; if (irq8 !== 1'b0) begin errors++; $display("FAIL reset_irq8: got %b want 0", irq8); end
    bus_rd(0, 3'd5, q);
    checks++; if (q !== 32'h000000A5) begin errors++; $display("FAIL reset_rd5: got %h want 000000a5", q); end
    bus_rd(0, 3'd1, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL reset_mask: got %h want 0", q); end
    checks++; if (outf !== 4'h9) begin errors++; $display("FAIL reset_outf: got %h want 9", outf); end
    bus_rd(2, 3'd5, q);
    checks++; if (q !== 32'h00000009) begin errors++; $display("FAIL reset_rdf5: got %h want 00000009", q); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_data_write;
    bus_wr(0, 3'd0, 32'hFFFFFF3C);
    checks++; if (out8 !== 8'h3C) begin errors++; $display("FAIL data_wr: got %h want 3c", out8); end
    bus_rd(0, 3'd0, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL data_rd_in: got %h want 0", q); end
    bus_rd(0, 3'd3, q);
    checks++; if (q !== 32'h3C) begin errors++; $display("FAIL data_rd3: got %h want 3c", q); end
    bus_rd(0, 3'd6, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL data_rd6: got %h want 0", q); end
    bus_rd(0, 3'd7, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL data_rd7: got %h want 0", q); end
  endtask

  task automatic test_set_clear;
    bus_wr(0, 3'd3, 32'hABCDEF81);
    checks++; if (out8 !== 8'hBD) begin errors++; $display("FAIL outset: got %h want bd", out8); end
    bus_wr(0, 3'd4, 32'h5555550C);
    checks++; if (out8 !== 8'hB1) begin errors++; $display("FAIL outclr: got %h want b1", out8); end
    bus_wr(0, 3'd5, 32'h000000FF);
    checks++; if (out8 !== 8'hB1) begin errors++; $display("FAIL dataout_wr: got %h want b1", out8); end
  endtask

  task automatic test_rising;
    bus_wr(0, 3'd1, 32'h00000001);
    bus_rd(0, 3'd1, q);
    checks++; if (q !== 32'h1) begin errors++; $display("FAIL mask_rd: got %h want 1", q); end
    in8 = 8'h01;
    repeat (2) @(negedge clk);
    bus_rd(0, 3'd0, q);
    checks++; if (q !== 32'h1) begin errors++; $display("FAIL rise_sync: got %h want 1", q); end
    bus_rd(0, 3'd2, q);
    checks++; if (q !== 32'h0 || irq8 !== 1'b0) begin errors++; $display("FAIL rise_early: got %h/%b want 0/0", q, irq8); end
    @(negedge clk);
    bus_rd(0, 3'd2, q);
    checks++; if (q !== 32'h1 || irq8 !== 1'b1) begin errors++; $display("FAIL rise_cap: got %h/%b want 1/1", q, irq8); end
    bus_wr(0, 3'd2, 32'h00000001);
    bus_rd(0, 3'd2, q);
    checks++; if (q !== 32'h0 || irq8 !== 1'b0) begin errors++; $display("FAIL rise_clr: got %h/%b want 0/0", q, irq8); end
    in8 = 8'h00;
    repeat (4) @(negedge clk);
    bus_rd(0, 3'd2, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL rise_nofall: got %h want 0", q); end
  endtask

  task automatic test_simultaneous;
    in8 = 8'h01;
    repeat (3) @(negedge clk);
    bus_rd(0, 3'd2, q);
    checks++; if (q !== 32'h1) begin errors++; $display("FAIL simul_setup: got %h want 1", q); end
    in8 = 8'h00;
    repeat (3) @(negedge clk);
    in8 = 8'h01;
    repeat (2) @(negedge clk);
    bus_drive(0, 3'd2, 32'h1, 1'b1, 1'b0);
    @(negedge clk);
    bus_drive(0, 3'd2, 32'h0, 1'b0, 1'b1);
    bus_rd(0, 3'd2, q);
    checks++; if (q !== 32'h1 || irq8 !== 1'b1) begin errors++; $display("FAIL simul_win: got %h/%b want 1/1", q, irq8); end
    bus_wr(0, 3'd2, 32'h1);
    bus_rd(0, 3'd2, q);
    checks++; if (q !== 32'h0 || irq8 !== 1'b0) begin errors++; $display("FAIL simul_clr: got %h/%b want 0/0", q, irq8); end
  endtask

  task automatic test_async_reset;
    in8 = 8'h00;
    repeat (3) @(negedge clk);
    in8 = 8'h01;
    repeat (3) @(negedge clk);
    checks++; if (irq8 !== 1'b1) begin errors++; $display("FAIL areset_pend: got %b want 1", irq8); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out8 !== 8'hA5 || irq8 !== 1'b0) begin errors++; $display("FAIL areset_now: got %h/%b want a5/0", out8, irq8); end
    bus_rd(0, 3'd2, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL areset_cap: got %h want 0", q); end
    bus_rd(0, 3'd1, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL areset_mask: got %h want 0", q); end
    bus_rd(0, 3'd0, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL areset_sync: got %h want 0", q); end
    in8 = 8'hFF;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    bus_rd(0, 3'd2, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL warmup_cap: got %h want 0", q); end
    bus_rd(0, 3'd0, q);
    checks++; if (q !== 32'hFF) begin errors++; $display("FAIL warmup_sync: got %h want ff", q); end
    in8 = 8'h00;
    repeat (3) @(negedge clk);
    in8 = 8'hFF;
    repeat (3) @(negedge clk);
    bus_rd(0, 3'd2, q);
    checks++; if (q !== 32'hFF || irq8 !== 1'b0) begin errors++; $display("FAIL armed_cap: got %h/%b want ff/0", q, irq8); end
  endtask

  task automatic test_any_edge_32;
    in32 = 32'h80000000;
    repeat (3) @(negedge clk);
    bus_rd(1, 3'd2, q);
    checks++; if (q !== 32'h80000000 || irq32 !== 1'b0) begin errors++; $display("FAIL any_rise: got %h/%b want 80000000/0", q, irq32); end
    bus_wr(1, 3'd1, 32'h80000000);
    checks++; if (irq32 !== 1'b1) begin errors++; $display("FAIL any_mask: got %b want 1", irq32); end
    bus_wr(1, 3'd2, 32'h80000000);
    checks++; if (irq32 !== 1'b0) begin errors++; $display("FAIL any_clr: got %b want 0", irq32); end
    in32 = 32'h0;
    repeat (3) @(negedge clk);
    bus_rd(1, 3'd2, q);
    checks++; if (q !== 32'h80000000 || irq32 !== 1'b1) begin errors++; $display("FAIL any_fall: got %h/%b want 80000000/1", q, irq32); end
  endtask

  task automatic test_falling;
    inf = 4'hF;
    repeat (5) @(negedge clk);
    bus_rd(2, 3'd2, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL fall_norise: got %h want 0", q); end
    inf = 4'h5;
    repeat (3) @(negedge clk);
    bus_rd(2, 3'd2, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL fall_early: got %h want 0", q); end
    @(negedge clk);
    bus_rd(2, 3'd2, q);
    checks++; if (q !== 32'hA) begin errors++; $display("FAIL fall_cap: got %h want a", q); end
    bus_wr(2, 3'd1, 32'hFFFFFFF2);
    bus_rd(2, 3'd1, q);
    checks++; if (q !== 32'h2 || irqf !== 1'b1) begin errors++; $display("FAIL fall_mask: got %h/%b want 2/1", q, irqf); end
    bus_rd(2, 3'd0, q);
    checks++; if (q !== 32'h5) begin errors++; $display("FAIL fall_sync: got %h want 5", q); end
  endtask

  initial begin
    in8 = '0; in32 = '0; inf = '0;
    bus_drive(0, 3'd0, 32'h0, 1'b0, 1'b1);
    bus_drive(1, 3'd0, 32'h0, 1'b0, 1'b1);
    bus_drive(2, 3'd0, 32'h0, 1'b0, 1'b1);
    test_reset;
    test_data_write;
    test_set_clear;
    test_rising;
    test_simultaneous;
    test_async_reset;
    test_any_edge_32;
    test_falling;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
